seg_fade_decoder: RTL
=====================

// Module: seg_fade_decoder
// PURPOSE
//  Receive-side companion to the 7-segment fading chaser: samples the 7 PWM-driven segment lines,
//  measures per-segment duty over one PWM frame, and recovers brightness levels, the chaser head
//  position (figure-8 state 0..7) and the step direction. Used as loopback checker / display monitor.
// PARAMETERS
//  PWM_BITS  5   log2 of slots per PWM frame (frame = 32 slots)
//  SLOT_DIV  64  clk cycles per slot; one sample per slot, taken when the prescaler wraps
//  HI_THR    28  level at/above which a segment counts as "lit"
// PORTS
//  clk         in   1  clock
//  reset       in   1  synchronous, active-high
//  seg_in      in   7  raw segment lines, bit i = segment i, asynchronous to clk
//  level_sel   in   3  selects segment whose level drives level_out (values 7 -> level_out=0)
//  level_out   out  5  registered level of selected segment, 0..31
//  frame_stb   out  1  1-cycle pulse: all levels updated
//  head_stb    out  1  1-cycle pulse: new head detected, head_pos/dir_* updated
//  head_pos    out  3  recovered chaser state 0..7
//  dir_valid   out  1  1 = last head step was a legal +/-1 move
//  dir_up      out  1  1 = state incremented, 0 = decremented (meaningful when dir_valid)
// BEHAVIOUR
//  - seg_in passes through a 2-flop synchronizer (2 cycles latency) before any use.
//  - Prescaler counts 0..SLOT_DIV-1; at wrap, one sample slot: cnt[i] += seg_s[i]; slot counter
//    increments. cnt[i] is PWM_BITS+1 wide (0..32).
//  - After the final slot (slot = 2^PWM_BITS-1) is sampled: next cycle level[i] <= min(cnt[i],31),
//    prev[i] <= old level[i], cnt cleared, frame_stb = 1 for that cycle. Slot wraps to 0.
//  - Head detect (cycle after frame_stb): newly lit = level[i]>=HI_THR && prev[i]<HI_THR.
//    If any, lowest index i wins -> head_stb=1 that cycle. No newly lit segment -> no head_stb.
//  - State->segment map: 0:s0 1:s1 2:s6 3:s4 4:s3 5:s2 6:s6 7:s5 (segment 6 appears twice).
//  - Position tracker, on head segment s with current pos p (arithmetic mod 8):
//      map[p+1]==s -> pos<=p+1, dir_valid<=1, dir_up<=1
//      else map[p-1]==s -> pos<=p-1, dir_valid<=1, dir_up<=0
//      else resync: pos <= lowest state k with map[k]==s (s6 -> 2), dir_valid<=0, dir_up holds
//    +1 checked before -1. More than one newly lit segment in a frame -> resync rule, dir_valid<=0.
//  - level_out registered: level[level_sel] one cycle after level_sel/level change.
//  - Reset: all outputs 0, cnt/level/prev/pos/prescaler/slot = 0, synchronizer flops = 0.
//    Reset mid-frame discards the partial frame; first frame_stb comes a full frame after release.
//  - Levels are exact duty counts; no filtering, no hysteresis beyond prev/HI_THR edge.
// CONFIGURATION
//  SEG_ACTIVE_LOW_EN defined: synchronized seg_in is inverted before counting (common-anode
//    drive, line low = segment on). Undefined: line high = segment on. No other change.
// TESTING (SLOT_DIV=1 for speed, macro undefined unless stated)
//  1 seg_in=7'h00 two frames -> all levels 0, frame_stb every 32 cycles, no head_stb.
//  2 seg0 high 16 of 32 slots, seg3 constant 1 -> level0=16, level3=31 (saturated), level_out
//    follows level_sel=0 then 3 with 1-cycle latency.
//  3 lit sequence s0,s1,s6,s4 one per frame -> head_pos 0,1,2,3; dir_valid=1, dir_up=1 from 2nd.
//  4 sequence s5,s6,s2 from pos 7 -> head_pos 6,5 with dir_up=0; then s4 -> resync to 3,
//    dir_valid=0.
//  5 s0 and s3 newly lit same frame -> head seg 0, resync, dir_valid=0.
//  6 reset asserted at slot 10 -> outputs 0, next frame_stb 32 cycles after release (+sync delay);
//    with SEG_ACTIVE_LOW_EN, seg_in=7'h7F steady -> all levels 0.

Source files
------------

// File: rtl/seg_fade_decoder.sv
// Receive-side monitor for the 7-segment fading chaser: measures per-segment PWM duty per frame and
// recovers chaser head position and step direction. Define SEG_ACTIVE_LOW_EN for common-anode lines.
module seg_fade_decoder #(
  parameter int PWM_BITS = 5,
  parameter int SLOT_DIV = 64,
  parameter int HI_THR   = 28
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic [2:0]          level_sel,
  output logic [PWM_BITS-1:0] level_out,
  output logic                frame_stb,
  output logic                head_stb,
  output logic [2:0]          head_pos,
  output logic                dir_valid,
  output logic                dir_up
);

  localparam int                PW        = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST  = PW'(SLOT_DIV - 1);
  localparam logic [PWM_BITS-1:0] SLOT_LAST = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] THR       = PWM_BITS'(HI_THR);

  logic [6:0]                     sync1_r, sync2_r, seg_s;
  logic [PW-1:0]                  presc_r;
  logic [PWM_BITS-1:0]            slot_r;
  logic                           wrap_s, done_r;
  logic [6:0][PWM_BITS:0]         cnt_r;
  logic [6:0][PWM_BITS-1:0]       level_r, prev_r;
  logic [6:0]                     newly_s;
  logic [2:0]                     head_seg_s;
  logic                           multi_s;

  // Figure-8 chaser: segment lit in each state (segment 6 appears at states 2 and 6).
  function automatic logic [2:0] seg_of_state(input logic [2:0] k);
    case (k)
      3'd0:    seg_of_state = 3'd0;
      3'd1:    seg_of_state = 3'd1;
      3'd2:    seg_of_state = 3'd6;
      3'd3:    seg_of_state = 3'd4;
      3'd4:    seg_of_state = 3'd3;
      3'd5:    seg_of_state = 3'd2;
      3'd6:    seg_of_state = 3'd6;
      default: seg_of_state = 3'd5;
    endcase
  endfunction

  function automatic logic [2:0] state_of_seg(input logic [2:0] s);
    case (s)
      3'd0:    state_of_seg = 3'd0;
      3'd1:    state_of_seg = 3'd1;
      3'd2:    state_of_seg = 3'd5;
      3'd3:    state_of_seg = 3'd4;
      3'd4:    state_of_seg = 3'd3;
      3'd5:    state_of_seg = 3'd7;
      3'd6:    state_of_seg = 3'd2;
      default: state_of_seg = 3'd0;
    endcase
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_level(input logic [PWM_BITS:0] c);
    if (c[PWM_BITS]) sat_level = {PWM_BITS{1'b1}};
    else             sat_level = c[PWM_BITS-1:0];
  endfunction

  // Two-flop synchronizer for the asynchronous segment lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 7'd0;
      sync2_r <= 7'd0;
    end else begin
      sync1_r <= seg_in;
      sync2_r <= sync1_r;
    end
  end

  // Polarity adjust: "on" is always 1 downstream.
  always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
    seg_s = ~sync2_r;
`else
    seg_s = sync2_r;
`endif
  end

  assign wrap_s = (presc_r == PRE_LAST);

  // Slot timing: prescaler, slot counter and end-of-frame flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
      slot_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      presc_r <= wrap_s ? '0 : presc_r + PW'(1);
      slot_r  <= wrap_s ? slot_r + PWM_BITS'(1) : slot_r;
      done_r  <= wrap_s && (slot_r == SLOT_LAST);
    end
  end

  // Duty accumulation and per-frame level capture; a slot-0 sample may coincide with the capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= '0;
      level_r   <= '0;
      prev_r    <= '0;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= done_r;
      for (int i = 0; i < 7; i++) begin
        if (done_r) begin
          level_r[i] <= sat_level(cnt_r[i]);
          prev_r[i]  <= level_r[i];
          cnt_r[i]   <= wrap_s ? {{PWM_BITS{1'b0}}, seg_s[i]} : '0;
        end else if (wrap_s) begin
          cnt_r[i]   <= cnt_r[i] + {{PWM_BITS{1'b0}}, seg_s[i]};
        end else begin
          cnt_r[i]   <= cnt_r[i];
        end
      end
    end
  end

  // Rising-edge detection across the threshold; lowest newly lit segment is the head.
  always_comb begin
    newly_s    = 7'd0;
    head_seg_s = 3'd0;
    for (int i = 0; i < 7; i++) begin
      newly_s[i] = (level_r[i] >= THR) && (prev_r[i] < THR);
    end
    for (int i = 6; i >= 0; i--) begin
      head_seg_s = newly_s[i] ? 3'(i) : head_seg_s;
    end
    multi_s = |(newly_s & (newly_s - 7'd1));
  end

  // Position tracker: +1 step preferred over -1, anything else resynchronises.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_stb  <= 1'b0;
      head_pos  <= 3'd0;
      dir_valid <= 1'b0;
      dir_up    <= 1'b0;
    end else if (frame_stb && (|newly_s)) begin
      head_stb <= 1'b1;
      if (!multi_s && (seg_of_state(head_pos + 3'd1) == head_seg_s)) begin
        head_pos  <= head_pos + 3'd1;
        dir_valid <= 1'b1;
        dir_up    <= 1'b1;
      end else if (!multi_s && (seg_of_state(head_pos - 3'd1) == head_seg_s)) begin
        head_pos  <= head_pos - 3'd1;
        dir_valid <= 1'b1;
        dir_up    <= 1'b0;
      end else begin
        head_pos  <= state_of_seg(head_seg_s);
        dir_valid <= 1'b0;
        dir_up    <= dir_up;
      end
    end else begin
      head_stb <= 1'b0;
    end
  end

  // Selected-level readout; selector value 7 reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_out <= '0;
    end else begin
      level_out <= (level_sel == 3'd7) ? '0 : level_r[level_sel];
    end
  end

endmodule
